// File: rtl/dsec_pkg.sv
// Shared types and constants for the output controller.
package dsec_pkg;

  localparam int unsigned DATA_W             = 64;
  localparam int unsigned CNT_W              = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] ERR_PUSH_FULL  = 64'h1;
  localparam logic [DATA_W-1:0] ERR_RCVD_EMPTY = 64'h2;
  localparam logic [DATA_W-1:0] ERR_TIMEOUT    = 64'h3;
  localparam logic [DATA_W-1:0] ERR_DUMP_BUSY  = 64'h4;

endpackage

// File: rtl/out_fifo2.sv
// Two-entry word buffer with a registered head-of-queue output.
// The caller guarantees push only when a slot is free or a pop happens in the same cycle.
module out_fifo2
  import dsec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              rd_ptr_nxt;

  assign rd_ptr_nxt = rd_ptr ^ pop;

  // Storage array; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and head word; head bypasses storage when the incoming word lands at the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      dout   <= '0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
      dout   <= (push && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/output_ctrl.sv
// Output controller: buffers shift-concat words toward the receiver, sequences the
// end-of-stream flush/drain, and latches protocol errors.
// Build option: define OUTPUT_CTRL_TIMEOUT_EN to enable the out_valid wait timeout.
module output_ctrl
  import dsec_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shcn_done,
  input  logic [DATA_W-1:0] shcn_data,
  input  logic              out_rcvd,
  input  logic              dump_req,
  input  logic              comp_flushed,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              buf_full,
  output logic              dump_comp,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] error_code
);

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              full;
  logic              push;
  logic              pop;
  logic              clr;
  logic              e_full;
  logic              e_rcvd;
  logic              e_tmo;
  logic              e_dump;
  logic              any_err;
  logic              tmo_hit;
  logic              dump_comp_d;
  logic              done_d;
  logic [DATA_W-1:0] code_d;

  assign full    = (count == CNT_W'(2));
  assign pop     = out_valid && out_rcvd && (state != ST_ERR);
  assign e_full  = shcn_done && full && !pop && (state != ST_ERR);
  assign e_rcvd  = out_rcvd && !out_valid && (state != ST_ERR);
  assign e_dump  = dump_req && (state != ST_IDLE) && (state != ST_ERR);
  assign e_tmo   = tmo_hit && (state != ST_ERR);
  assign any_err = e_full || e_rcvd || e_tmo || e_dump;
  assign push    = shcn_done && (state != ST_ERR) && !e_full;
  assign clr     = (state == ST_ERR) && err_clr;
  assign count_nxt = clr ? '0 : CNT_W'(count + CNT_W'(push) - CNT_W'(pop));

  out_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (shcn_data),
    .dout  (data_out),
    .count (count)
  );

`ifdef OUTPUT_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = out_valid && !out_rcvd && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive cycles a valid word waits unaccepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (!out_valid || out_rcvd || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  // No wait limit in this build; the parameter has no hardware behind it.
  assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Next state, one-cycle strobes and error-code selection (lowest code wins).
  always_comb begin
    state_d     = state;
    dump_comp_d = 1'b0;
    done_d      = 1'b0;
    code_d      = ERR_DUMP_BUSY;
    unique case (state)
      ST_IDLE: begin
        if (dump_req) begin
          state_d     = ST_FLUSH;
          dump_comp_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (comp_flushed) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_ERR: begin
        if (err_clr) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (e_tmo)  code_d = ERR_TIMEOUT;
    if (e_rcvd) code_d = ERR_RCVD_EMPTY;
    if (e_full) code_d = ERR_PUSH_FULL;
    if (any_err) begin
      state_d     = ST_ERR;
      dump_comp_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  // State register and registered status outputs derived from next-cycle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      buf_full   <= 1'b0;
      dump_comp  <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= '0;
    end else begin
      state     <= state_d;
      out_valid <= (count_nxt != '0) && (state_d != ST_ERR);
      buf_full  <= (count_nxt == CNT_W'(2)) || (state_d == ST_ERR);
      dump_comp <= dump_comp_d;
      done      <= done_d;
      error     <= (state_d == ST_ERR);
      if (any_err) begin
        error_code <= code_d;
      end
    end
  end

endmodule

// File: tb/tb_output_ctrl.sv
// Self-checking bench for output_ctrl: cycle vector table plus timeout and async-reset sequences.
module tb_output_ctrl;

  localparam logic [63:0] WA = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] WB = 64'hA5A5_0000_0000_0002;
  localparam logic [63:0] WC = 64'hA5A5_0000_0000_0003;
  localparam logic [63:0] WD = 64'hA5A5_0000_0000_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        shcn_done;
  logic [63:0] shcn_data;
  logic        out_rcvd;
  logic        dump_req;
  logic        comp_flushed;
  logic        err_clr;
  logic [63:0] data_out;
  logic        out_valid;
  logic        buf_full;
  logic        dump_comp;
  logic        done;
  logic        error;
  logic [63:0] error_code;

  always #5 clk = ~clk;

  output_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .shcn_done    (shcn_done),
    .shcn_data    (shcn_data),
    .out_rcvd     (out_rcvd),
    .dump_req     (dump_req),
    .comp_flushed (comp_flushed),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .buf_full     (buf_full),
    .dump_comp    (dump_comp),
    .done         (done),
    .error        (error),
    .error_code   (error_code)
  );

  typedef struct {
    logic        sd;
    logic [63:0] data;
    logic        rcv;
    logic        dmp;
    logic        cf;
    logic        clr;
    logic        ov;
    logic        bf;
    logic        dc;
    logic        dn;
    logic        er;
    logic [63:0] code;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          row   = 0;
  logic        m_ov, m_full, m_err;
  logic [63:0] lc;

  function automatic vec_t mk(input logic sd, input logic [63:0] d, input logic rcv, input logic dmp,
                              input logic cf, input logic clr, input logic ov, input logic bf,
                              input logic dc, input logic dn, input logic er, input logic [63:0] code);
    vec_t v;
    v.sd = sd; v.data = d; v.rcv = rcv; v.dmp = dmp; v.cf = cf; v.clr = clr;
    v.ov = ov; v.bf = bf; v.dc = dc; v.dn = dn; v.er = er; v.code = code;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ov = 1'b0; m_full = 1'b0; m_err = 1'b0;
  endtask

  // Drive one cycle of stimulus, keep the scoreboard, then check registered outputs after the edge.
  task automatic apply(input vec_t v);
    logic pop_m;
    string tag;
    tag = $sformatf("r%0d", row);
    shcn_done = v.sd; shcn_data = v.data; out_rcvd = v.rcv;
    dump_req = v.dmp; comp_flushed = v.cf; err_clr = v.clr;
    pop_m = v.rcv && m_ov && !m_err;
    if (pop_m) begin
      if (sb.size() == 0) begin
        chk({tag, ".pop_sb_empty"}, 64'd1, 64'd0);
      end else begin
        chk({tag, ".pop_data"}, data_out, sb[0]);
        void'(sb.pop_front());
      end
    end
    if (v.sd && !m_err && !(m_full && !pop_m)) sb.push_back(v.data);
    if (v.clr && m_err) sb.delete();
    @(posedge clk); #1;
    chk({tag, ".out_valid"},  64'(out_valid), 64'(v.ov));
    chk({tag, ".buf_full"},   64'(buf_full),  64'(v.bf));
    chk({tag, ".dump_comp"},  64'(dump_comp), 64'(v.dc));
    chk({tag, ".done"},       64'(done),      64'(v.dn));
    chk({tag, ".error"},      64'(error),     64'(v.er));
    chk({tag, ".error_code"}, error_code,     v.code);
    if (v.ov) begin
      if (sb.size() == 0) chk({tag, ".head_sb_empty"}, 64'd1, 64'd0);
      else                chk({tag, ".head_data"}, data_out, sb[0]);
    end
    m_ov = v.ov; m_full = v.bf && !v.er; m_err = v.er;
    row++;
  endtask

  task automatic idle(input logic ov, input logic bf, input logic er, input logic [63:0] code);
    apply(mk(0, 64'd0, 0, 0, 0, 0, ov, bf, 0, 0, er, code));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".data_out"},   data_out,        64'd0);
    chk({tag, ".out_valid"},  64'(out_valid),  64'd0);
    chk({tag, ".buf_full"},   64'(buf_full),   64'd0);
    chk({tag, ".dump_comp"},  64'(dump_comp),  64'd0);
    chk({tag, ".done"},       64'(done),       64'd0);
    chk({tag, ".error"},      64'(error),      64'd0);
    chk({tag, ".error_code"}, error_code,      64'd0);
  endtask

  initial begin
    rst = 1'b1;
    shcn_done = 0; shcn_data = '0; out_rcvd = 0; dump_req = 0; comp_flushed = 0; err_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Two pushes fill the buffer, then drain in order.
    vecs.push_back(mk(1, WA,    0,0,0,0, 1,0,0,0,0, 64'd0));
    vecs.push_back(mk(1, WB,    0,0,0,0, 1,1,0,0,0, 64'd0));
    vecs.push_back(mk(0, 64'd0, 0,0,0,0, 1,1,0,0,0, 64'd0));
    vecs.push_back(mk(0, 64'd0, 1,0,0,0, 1,0,0,0,0, 64'd0));
    vecs.push_back(mk(0, 64'd0, 1,0,0,0, 0,0,0,0,0, 64'd0));
    // Full: push+pop is legal, push alone is an overflow error; ERR ignores inputs.
    vecs.push_back(mk(1, WC,    0,0,0,0, 1,0,0,0,0, 64'd0));
    vecs.push_back(mk(1, WD,    0,0,0,0, 1,1,0,0,0, 64'd0));
    vecs.push_back(mk(1, WA,    1,0,0,0, 1,1,0,0,0, 64'd0));
    vecs.push_back(mk(1, WB,    0,0,0,0, 0,1,0,0,1, 64'd1));
    vecs.push_back(mk(1, WC,    1,1,0,0, 0,1,0,0,1, 64'd1));
    vecs.push_back(mk(0, 64'd0, 0,0,0,1, 0,0,0,0,0, 64'd1));
    // Flush with one buffered word; done after the last word leaves.
    vecs.push_back(mk(1, WA,    0,0,0,0, 1,0,0,0,0, 64'd1));
    vecs.push_back(mk(0, 64'd0, 0,1,0,0, 1,0,1,0,0, 64'd1));
    vecs.push_back(mk(0, 64'd0, 0,0,0,0, 1,0,0,0,0, 64'd1));
    vecs.push_back(mk(0, 64'd0, 0,0,0,0, 1,0,0,0,0, 64'd1));
    vecs.push_back(mk(0, 64'd0, 0,0,1,0, 1,0,0,0,0, 64'd1));
    vecs.push_back(mk(0, 64'd0, 0,0,0,0, 1,0,0,0,0, 64'd1));
    vecs.push_back(mk(0, 64'd0, 1,0,0,0, 0,0,0,0,0, 64'd1));
    vecs.push_back(mk(0, 64'd0, 0,0,0,0, 0,0,0,1,0, 64'd1));
    vecs.push_back(mk(0, 64'd0, 0,0,0,0, 0,0,0,0,0, 64'd1));
    // Simultaneous codes 2 and 4 in FLUSH record 2; clear keeps the code.
    vecs.push_back(mk(0, 64'd0, 0,1,0,0, 0,0,1,0,0, 64'd1));
    vecs.push_back(mk(0, 64'd0, 1,1,0,0, 0,1,0,0,1, 64'd2));
    vecs.push_back(mk(0, 64'd0, 0,0,0,1, 0,0,0,0,0, 64'd2));
    // Drain entered empty: done one cycle later.
    vecs.push_back(mk(0, 64'd0, 0,1,0,0, 0,0,1,0,0, 64'd2));
    vecs.push_back(mk(0, 64'd0, 0,0,1,0, 0,0,0,0,0, 64'd2));
    vecs.push_back(mk(0, 64'd0, 0,0,0,0, 0,0,0,1,0, 64'd2));
    vecs.push_back(mk(0, 64'd0, 0,0,0,0, 0,0,0,0,0, 64'd2));
    // dump_req outside IDLE.
    vecs.push_back(mk(0, 64'd0, 0,1,0,0, 0,0,1,0,0, 64'd2));
    vecs.push_back(mk(0, 64'd0, 0,1,0,0, 0,1,0,0,1, 64'd4));
    vecs.push_back(mk(0, 64'd0, 0,0,0,1, 0,0,0,0,0, 64'd4));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    lc = 64'd4;

    // Word held without acceptance.
    apply(mk(1, WB, 0,0,0,0, 1,0,0,0,0, lc));
`ifdef OUTPUT_CTRL_TIMEOUT_EN
    for (int i = 0; i < 15; i++) idle(1, 0, 0, lc);
    idle(0, 1, 1, 64'd3);
    lc = 64'd3;
    apply(mk(0, 64'd0, 0,0,0,1, 0,0,0,0,0, lc));
`else
    for (int i = 0; i < 100; i++) idle(1, 0, 0, lc);
    apply(mk(0, 64'd0, 1,0,0,0, 0,0,0,0,0, lc));
`endif

    // Reset mid-DRAIN with two words buffered.
    apply(mk(1, WC, 0,0,0,0, 1,0,0,0,0, lc));
    apply(mk(1, WD, 0,0,0,0, 1,1,0,0,0, lc));
    apply(mk(0, 64'd0, 0,1,0,0, 1,1,1,0,0, lc));
    apply(mk(0, 64'd0, 0,0,1,0, 1,1,0,0,0, lc));
    idle(1, 1, 0, lc);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) idle(0, 0, 0, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/output_ctrl.md
OUTPUT_CTRL -- requirements
Module: output_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, cycles out_valid may wait for out_rcvd before timeout error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 shcn_done  input  1  shift-concatenation word ready, one-cycle push strobe.
REQ-005 shcn_data  input  64  word pushed when shcn_done high.
REQ-006 out_rcvd  input  1  receiving device accepts data_out this cycle.
REQ-007 dump_req  input  1  end-of-stream pulse, request compression flush.
REQ-008 comp_flushed  input  1  compression module has emitted its remaining data.
REQ-009 err_clr  input  1  clears a latched error.
REQ-010 data_out  output  64  head-of-buffer word.
REQ-011 out_valid  output  1  data_out valid.
REQ-012 buf_full  output  1  buffer holds 2 words; upstream must stall.
REQ-013 dump_comp  output  1  one-cycle flush command to compression module.
REQ-014 done  output  1  one-cycle pulse, stream fully drained.
REQ-015 error  output  1  error latched.
REQ-016 error_code  output  64  code of last error encountered.

Function
REQ-017 Buffer SHALL be a 2-entry FIFO of 64-bit words; push on shcn_done, pop on out_valid && out_rcvd.
REQ-018 out_valid SHALL be high iff buffer non-empty and state != ERR; data_out SHALL be the oldest word; zero added latency beyond one registered push (word visible cycle after shcn_done).
REQ-019 buf_full SHALL equal (count == 2), or 1 in ERR.
REQ-020 Push and pop in the same cycle SHALL both occur, count unchanged, including when full (no overflow).
REQ-021 FSM states IDLE, FLUSH, DRAIN, ERR; IDLE is reset state.
REQ-022 IDLE: dump_req -> FLUSH, dump_comp high for exactly that transition cycle+1 (one cycle).
REQ-023 FLUSH: pushes still accepted; comp_flushed -> DRAIN.
REQ-024 DRAIN: when count == 0 -> IDLE with done pulsed one cycle; if already empty on entry, done next cycle.
REQ-025 Error codes: 64'h1 push while full without pop; 64'h2 out_rcvd while out_valid low; 64'h3 timeout; 64'h4 dump_req outside IDLE.
REQ-026 Any error SHALL move to ERR, set error, load error_code; simultaneous errors SHALL record the lowest code.
REQ-027 ERR: shcn_done, out_rcvd, dump_req ignored; no further codes latched.
REQ-028 err_clr in ERR SHALL empty the buffer, clear error, return to IDLE; error_code SHALL retain its value; err_clr outside ERR has no effect.

Reset
REQ-029 rst SHALL asynchronously set: state IDLE, count 0, read/write pointers 0, data_out 0, out_valid 0, buf_full 0, dump_comp 0, done 0, error 0, error_code 0, timeout counter 0.
REQ-030 rst mid-stream SHALL discard buffered words; no done pulse on release.

Configuration
REQ-031 Macro OUTPUT_CTRL_TIMEOUT_EN defined: counter increments each cycle out_valid && !out_rcvd, clears on pop or out_valid low; reaching TIMEOUT_CYCLES raises code 64'h3.
REQ-032 Macro undefined: no counter hardware, code 64'h3 never produced, out_valid may wait indefinitely.

Structure
REQ-033 Package dsec_pkg SHALL hold the FSM state typedef, the four error-code constants and default TIMEOUT_CYCLES.
REQ-034 The 2-entry buffer SHALL be sub-module out_fifo2 (push, pop, din, dout, count); FSM, error and timeout logic in output_ctrl.

Verification
REQ-035 Push A5A5_0000_0000_0001 then ..._0002, out_rcvd low -> buf_full=1, data_out=...0001; out_rcvd 2 cycles -> ...0001 then ...0002 out, out_valid 0.
REQ-036 Buffer full, shcn_done with out_rcvd same cycle -> no error, count stays 2; shcn_done without out_rcvd -> error=1, error_code=64'h1, out_valid=0.
REQ-037 One word buffered, dump_req -> dump_comp 1 cycle; comp_flushed after 3 cycles, out_rcvd later -> done pulses exactly once, state IDLE.
REQ-038 With OUTPUT_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, word held 16 cycles unaccepted -> error_code=64'h3; without macro, 100 cycles -> error=0.
REQ-039 out_rcvd with empty buffer and dump_req in FLUSH same cycle -> error_code=64'h2; err_clr -> error=0, error_code still 64'h2, out_valid=0.
REQ-040 rst asserted mid-DRAIN with 2 words -> all outputs 0 immediately (before next edge), no done after release.
